fault_injector: RTL and testbench
=================================

Name: fault_injector

Overview:
- Synthesizable, parametrised fault injector for the lockstep/FT core.
- Sits between the instruction memory and the fetch ports of NUM_CH replica cores.
- Corrupts the fetched word of one selected channel under LFSR-driven probability, within an address window, in one of four corruption modes.
- Tracks injected, detected and missed faults against the FT monitor's error flag; replaces testbench-only force-based injection so campaigns can run on FPGA.

Parameters:
NUM_CH, 2, number of replica fetch channels
DATA_W, 32, instruction word width
ADDR_W, 32, fetch address width
MAX_INJ, 10, injections per campaign before DONE
PROB_W, 8, probability resolution in bits
DET_TIMEOUT, 64, cycles to wait for detection before declaring a miss
LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 1
CNT_W, 16, statistics counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  campaign enable (level)
clear_i  in  1  one-cycle pulse; zeroes the statistics counters
mode_i  in  2  0 REPLACE, 1 FLIP, 2 STUCK0, 3 STUCK1
ch_sel_i  in  $clog2(NUM_CH)  target channel
prob_i  in  PROB_W+1  injection threshold (0 = never, 2^PROB_W = always)
pattern_i  in  DATA_W  replacement word or bit mask
addr_lo_i  in  ADDR_W  window start (inclusive)
addr_hi_i  in  ADDR_W  window end (exclusive)
valid_i  in  NUM_CH  fetch data valid per channel
addr_i  in  NUM_CH*ADDR_W  fetch address per channel
data_i  in  NUM_CH*DATA_W  fetched word per channel
data_o  out  NUM_CH*DATA_W  possibly corrupted word per channel
inject_o  out  NUM_CH  one-hot, high in the corrupting cycle
error_detected_i  in  1  FT monitor error flag
busy_o  out  1  state is ARMED or WAIT_DET
done_o  out  1  state is DONE
inj_count_o  out  CNT_W  injections performed
det_count_o  out  CNT_W  injections detected
miss_count_o  out  CNT_W  detection timeouts

Behaviour:
- Reset: state IDLE; LFSR = LFSR_SEED (1 if the seed is 0); all counters 0; timer 0; busy_o, done_o and inject_o are 0; data_o = data_i.
- data_o is a combinational pass-through on every channel, except the selected channel in the fire cycle.
  - REPLACE: pattern.
  - FLIP: data ^ pattern.
  - STUCK0: data & ~pattern.
  - STUCK1: data | pattern.
- Fire condition, zero latency: state ARMED, valid_i[ch], addr_lo_i <= addr_i[ch] < addr_hi_i (unsigned), and {1'b0, lfsr[PROB_W-1:0]} < prob_i.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances every cycle the state is not IDLE and holds in IDLE.
- FSM:
  - IDLE -> ARMED when enable_i=1.
  - ARMED, on fire: inject_o[ch]=1 for one cycle, inj_count+1, timer=0, -> WAIT_DET.
  - WAIT_DET: timer increments each cycle.
    - error_detected_i=1 -> det_count+1.
    - Otherwise, when timer == DET_TIMEOUT-1 -> miss_count+1.
    - In either case, next state is DONE if inj_count == MAX_INJ, else ARMED.
  - DONE -> IDLE when enable_i=0.
  - enable_i=0 in ARMED or WAIT_DET -> IDLE. A pending WAIT_DET is abandoned (neither detected nor missed). Counters hold.
- Simultaneous events:
  - error_detected_i in the fire cycle is ignored; detection counts only in WAIT_DET.
  - Detection and timeout in the same cycle count as detected.
  - clear_i together with an increment: clear wins and the counter becomes 0.
- Counters saturate at all-ones.
- ch_sel_i >= NUM_CH: no injection ever fires.
- addr_lo_i >= addr_hi_i: empty window, no injection.
- Reset mid-operation returns to the reset state at the next edge regardless of state.

Optional Feature:
- FI_LATENCY_EN defined: adds output lat_max_o [$clog2(DET_TIMEOUT+1)].
  - Holds the maximum timer+1 observed on detection.
  - Reset value 0; cleared by clear_i.
- Undefined: port and register are absent.

Decomposition:
- Package fi_pkg:
  - fi_mode_e (REPLACE/FLIP/STUCK0/STUCK1).
  - fi_state_e (IDLE/ARMED/WAIT_DET/DONE).
  - LFSR polynomial constant.
  - Corrupt function (mode, data, pattern).
- Sub-module fi_lfsr: 16-bit Galois LFSR with seed, enable and zero-seed guard.

Test Plan:
- prob_i=256, mode REPLACE, pattern 32'h02A50533, window [0,0x100), ch_sel=1, valid/addr 0x40, enable=1 -> inject_o=2'b10 in the first ARMED cycle; data_o[1]=0x02A50533; data_o[0]=data_i[0].
- FLIP pattern 0x1, error_detected_i pulsed 3 cycles after each fire, MAX_INJ=10 -> inj=10, det=10, miss=0, done_o=1.
- error_detected_i never asserted, DET_TIMEOUT=64 -> each miss at exactly 64 cycles after fire; miss_count=10.
- addr_i=0x100 with window [0,0x100), or prob_i=0 -> no inject_o over 1000 cycles; counters stay 0.
- enable_i dropped in WAIT_DET, then reasserted -> IDLE entered; counters unchanged; new injection occurs.
- rst_i asserted in WAIT_DET -> next cycle all outputs at reset values; LFSR = seed.

Source files
------------

// File: rtl/fi_pkg.sv
// Shared types and helpers for the fault injector: corruption modes, FSM
// states, the LFSR feedback polynomial and the word corruption function.
package fi_pkg;

    // Corruption applied to the selected channel's fetched word.
    typedef enum logic [1:0] {
        REPLACE = 2'd0,
        FLIP    = 2'd1,
        STUCK0  = 2'd2,
        STUCK1  = 2'd3
    } fi_mode_e;

    // Campaign sequencing states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        WAIT_DET = 2'd2,
        DONE     = 2'd3
    } fi_state_e;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // Widest instruction word the corruption helper handles; callers
    // zero-extend narrower words and truncate the result.
    localparam int FI_MAX_W = 64;

    function automatic logic [FI_MAX_W-1:0] fi_corrupt(
        input fi_mode_e            mode,
        input logic [FI_MAX_W-1:0] data,
        input logic [FI_MAX_W-1:0] pattern
    );
        logic [FI_MAX_W-1:0] res;
        case (mode)
            REPLACE: res = pattern;
            FLIP:    res = data ^ pattern;
            STUCK0:  res = data & ~pattern;
            default: res = data | pattern;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fi_lfsr.sv
// 16-bit Galois LFSR used as the injection dice. Holds while en_i is low.
// A zero seed would lock the register at zero, so it is replaced by 1.
module fi_lfsr
    import fi_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [OUT_W-1:0] rnd_o
);

    localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == 16'h0) ? 16'h1 : SEED;

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Shift right; the bit falling out folds the polynomial back in.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_POLY : '0);
        end
    end

    // State register with synchronous reset to the (guarded) seed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED_SAFE;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/fault_injector.sv
// Fetch-path fault injector for the lockstep core. Passes instruction words
// through to NUM_CH replica fetch ports and, while a campaign is armed,
// corrupts the selected channel's word when the address falls inside the
// window and the LFSR dice beat prob_i. Counts injections, detections by the
// FT monitor and detection timeouts.
// Optional: define FI_LATENCY_EN to add lat_max_o, the worst detection
// latency (cycles from fire to detection) seen since the last clear.
module fault_injector
    import fi_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          MAX_INJ     = 10,
    parameter int          PROB_W      = 8,
    parameter int          DET_TIMEOUT = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          CNT_W       = 16,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int         TMR_W       = $clog2(DET_TIMEOUT + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [1:0]               mode_i,
    input  logic [CH_W-1:0]          ch_sel_i,
    input  logic [PROB_W:0]          prob_i,
    input  logic [DATA_W-1:0]        pattern_i,
    input  logic [ADDR_W-1:0]        addr_lo_i,
    input  logic [ADDR_W-1:0]        addr_hi_i,
    input  logic [NUM_CH-1:0]        valid_i,
    input  logic [NUM_CH*ADDR_W-1:0] addr_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    output logic [NUM_CH*DATA_W-1:0] data_o,
    output logic [NUM_CH-1:0]        inject_o,
    input  logic                     error_detected_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [CNT_W-1:0]         inj_count_o,
    output logic [CNT_W-1:0]         det_count_o,
    output logic [CNT_W-1:0]         miss_count_o
`ifdef FI_LATENCY_EN
    ,
    output logic [TMR_W-1:0]         lat_max_o
`endif
);

    fi_state_e        state_q;
    logic [TMR_W-1:0] timer_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] inj_q,  inj_d;
    logic [CNT_W-1:0] det_q,  det_d;
    logic [CNT_W-1:0] miss_q, miss_d;

    logic [PROB_W-1:0] rnd;
    logic              armed;
    logic              prob_hit;
    logic [NUM_CH-1:0] fire_vec;
    logic              fire;
    logic              det_evt;
    logic              miss_evt;

    // The dice roll every cycle a campaign is in progress, and hold in IDLE.
    fi_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (PROB_W)
    ) u_lfsr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (state_q != IDLE),
        .rnd_o (rnd)
    );

    // Dropping enable wins over a pending fire so an aborted campaign never
    // corrupts a word on its way out.
    assign armed    = (state_q == ARMED) && enable_i;
    assign prob_hit = {1'b0, rnd} < prob_i;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ADDR_W-1:0] ch_addr;
        logic [DATA_W-1:0] ch_data;

        assign ch_addr = addr_i[c*ADDR_W +: ADDR_W];
        assign ch_data = data_i[c*DATA_W +: DATA_W];

        // An out-of-range ch_sel_i matches no channel; an empty window
        // (lo >= hi) can never satisfy both bounds.
        assign fire_vec[c] = armed && prob_hit && valid_i[c]
                          && (ch_sel_i == CH_W'(c))
                          && (ch_addr >= addr_lo_i) && (ch_addr < addr_hi_i);

        assign data_o[c*DATA_W +: DATA_W] = fire_vec[c]
            ? DATA_W'(fi_corrupt(fi_mode_e'(mode_i), FI_MAX_W'(ch_data), FI_MAX_W'(pattern_i)))
            : ch_data;
    end

    assign fire     = |fire_vec;
    assign inject_o = fire_vec;

    // Detection beats a simultaneous timeout; both need the campaign enabled.
    assign det_evt  = (state_q == WAIT_DET) && enable_i && error_detected_i;
    assign miss_evt = (state_q == WAIT_DET) && enable_i && !error_detected_i
                   && (timer_q == TMR_W'(DET_TIMEOUT - 1));

    // Statistics next-state: saturating increments, clear has priority.
    always_comb begin
        inj_d  = inj_q;
        det_d  = det_q;
        miss_d = miss_q;
        if (fire     && (inj_q  != '1)) inj_d  = inj_q  + 1'b1;
        if (det_evt  && (det_q  != '1)) det_d  = det_q  + 1'b1;
        if (miss_evt && (miss_q != '1)) miss_d = miss_q + 1'b1;
        if (clear_i) begin
            inj_d  = '0;
            det_d  = '0;
            miss_d = '0;
        end
    end

    // Campaign FSM with detection timer and registered status outputs.
    always_ff @(posedge clk_i) begin
        fi_state_e nxt;
        if (rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: nxt is a block-local temporary, so it is written with '=' and
            // read immediately; all real state below uses '<='.
            nxt = state_q;
            case (state_q)
                IDLE: begin
                    if (enable_i) nxt = ARMED;
                end
                ARMED: begin
                    if (!enable_i) begin
                        nxt = IDLE;
                    end else if (fire) begin
                        nxt = WAIT_DET;
                    end
                end
                WAIT_DET: begin
                    if (!enable_i) begin
                        nxt = IDLE;
                    end else if (det_evt || miss_evt) begin
                        nxt = (inj_q == CNT_W'(MAX_INJ)) ? DONE : ARMED;
                    end
                end
                default: begin
                    if (!enable_i) nxt = IDLE;
                end
            endcase

            if (state_q == ARMED) begin
                timer_q <= '0;
            end else if (state_q == WAIT_DET) begin
                timer_q <= timer_q + 1'b1;
            end

            state_q <= nxt;
            busy_q  <= (nxt == ARMED) || (nxt == WAIT_DET);
            done_q  <= (nxt == DONE);
        end
    end

    // Statistics counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inj_q  <= '0;
            det_q  <= '0;
            miss_q <= '0;
        end else begin
            inj_q  <= inj_d;
            det_q  <= det_d;
            miss_q <= miss_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign inj_count_o  = inj_q;
    assign det_count_o  = det_q;
    assign miss_count_o = miss_q;

`ifdef FI_LATENCY_EN
    logic [TMR_W-1:0] lat_q;
    logic [TMR_W-1:0] lat_d;
    logic [TMR_W-1:0] lat_now;

    // Detection in the cycle with timer t happened t+1 cycles after fire.
    assign lat_now = timer_q + 1'b1;

    // Worst-case detection latency next-state; clear has priority.
    always_comb begin
        lat_d = lat_q;
        if (det_evt && (lat_now > lat_q)) lat_d = lat_now;
        if (clear_i) lat_d = '0;
    end

    // Worst-case detection latency register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lat_q <= '0;
        end else begin
            lat_q <= lat_d;
        end
    end

    assign lat_max_o = lat_q;
`endif

endmodule

// File: tb/tb_fault_injector.sv
// Self-checking bench for fault_injector (default build). A behavioural
// model tracks the campaign from the rules (phase, elapsed cycles since the
// last fire, integer statistics) and is compared against the DUT every
// cycle; directed literal checks pin the model at key points.
module tb_fault_injector;

    localparam int          NUM_CH      = 2;
    localparam int          DATA_W      = 32;
    localparam int          ADDR_W      = 32;
    localparam int          MAX_INJ     = 10;
    localparam int          PROB_W      = 8;
    localparam int          DET_TIMEOUT = 64;
    localparam int          CNT_W       = 16;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic                     clk = 1'b0;
    logic                     rst_i;
    logic                     enable_i;
    logic                     clear_i;
    logic [1:0]               mode_i;
    logic [0:0]               ch_sel_i;
    logic [PROB_W:0]          prob_i;
    logic [DATA_W-1:0]        pattern_i;
    logic [ADDR_W-1:0]        addr_lo_i;
    logic [ADDR_W-1:0]        addr_hi_i;
    logic [NUM_CH-1:0]        valid_i;
    logic [NUM_CH*ADDR_W-1:0] addr_i;
    logic [NUM_CH*DATA_W-1:0] data_i;
    logic [NUM_CH*DATA_W-1:0] data_o;
    logic [NUM_CH-1:0]        inject_o;
    logic                     error_detected_i;
    logic                     busy_o;
    logic                     done_o;
    logic [CNT_W-1:0]         inj_count_o;
    logic [CNT_W-1:0]         det_count_o;
    logic [CNT_W-1:0]         miss_count_o;

    always #5 clk = ~clk;

    fault_injector #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .MAX_INJ     (MAX_INJ),
        .PROB_W      (PROB_W),
        .DET_TIMEOUT (DET_TIMEOUT),
        .LFSR_SEED   (SEED),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .enable_i         (enable_i),
        .clear_i          (clear_i),
        .mode_i           (mode_i),
        .ch_sel_i         (ch_sel_i),
        .prob_i           (prob_i),
        .pattern_i        (pattern_i),
        .addr_lo_i        (addr_lo_i),
        .addr_hi_i        (addr_hi_i),
        .valid_i          (valid_i),
        .addr_i           (addr_i),
        .data_i           (data_i),
        .data_o           (data_o),
        .inject_o         (inject_o),
        .error_detected_i (error_detected_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .inj_count_o      (inj_count_o),
        .det_count_o      (det_count_o),
        .miss_count_o     (miss_count_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases: 0 idle, 1 armed, 2 waiting for detection, 3 done.
    int          m_phase = 0;
    logic [15:0] m_lfsr  = SEED;
    int          m_inj   = 0;
    int          m_det   = 0;
    int          m_miss  = 0;
    longint      cyc     = 0;
    longint      m_fire_cyc = 0;
    bit          cmp_en  = 1'b0;

    // Galois step built from the polynomial exponents 16,14,13,11.
    function automatic logic [15:0] m_step(input logic [15:0] s);
        int          taps [4] = '{16, 14, 13, 11};
        logic [15:0] mask;
        mask = '0;
        foreach (taps[i]) mask[taps[i]-1] = 1'b1;
        return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
    endfunction

    function automatic int sat(input int x);
        return (x == (1 << CNT_W) - 1) ? x : x + 1;
    endfunction

    always @(negedge clk) begin : model
        logic [NUM_CH-1:0]        e_inj;
        logic [NUM_CH*DATA_W-1:0] e_data;
        logic [ADDR_W-1:0]        a;
        logic [DATA_W-1:0]        d;
        logic [DATA_W-1:0]        w;
        int                       nph, ninj, ndet, nmiss;
        bit                       resolved;

        e_inj  = '0;
        e_data = data_i;
        for (int c = 0; c < NUM_CH; c++) begin
            a = addr_i[c*ADDR_W +: ADDR_W];
            d = data_i[c*DATA_W +: DATA_W];
            if (m_phase == 1 && enable_i && int'(ch_sel_i) == c && valid_i[c]
                && a >= addr_lo_i && a < addr_hi_i
                && int'(m_lfsr % (1 << PROB_W)) < int'(prob_i)) begin
                e_inj[c] = 1'b1;
                case (mode_i)
                    2'd0:    w = pattern_i;
                    2'd1:    w = d ^ pattern_i;
                    2'd2:    w = d & ~pattern_i;
                    default: w = d | pattern_i;
                endcase
                e_data[c*DATA_W +: DATA_W] = w;
            end
        end

        if (cmp_en) begin
            check("data_o",       data_o,       e_data);
            check("inject_o",     inject_o,     e_inj);
            check("busy_o",       busy_o,       (m_phase == 1 || m_phase == 2));
            check("done_o",       done_o,       (m_phase == 3));
            check("inj_count_o",  inj_count_o,  m_inj);
            check("det_count_o",  det_count_o,  m_det);
            check("miss_count_o", miss_count_o, m_miss);
        end

        if (rst_i) begin
            m_phase = 0;
            m_lfsr  = (SEED == 16'h0) ? 16'h1 : SEED;
            m_inj   = 0;
            m_det   = 0;
            m_miss  = 0;
        end else begin
            nph   = m_phase;
            ninj  = m_inj;
            ndet  = m_det;
            nmiss = m_miss;
            case (m_phase)
                0: if (enable_i) nph = 1;
                1: begin
                    if (!enable_i) nph = 0;
                    else if (|e_inj) begin
                        ninj       = sat(m_inj);
                        m_fire_cyc = cyc;
                        nph        = 2;
                    end
                end
                2: begin
                    if (!enable_i) nph = 0;
                    else begin
                        resolved = 1'b0;
                        if (error_detected_i) begin
                            ndet = sat(m_det);
                            resolved = 1'b1;
                        end else if (cyc - m_fire_cyc == DET_TIMEOUT) begin
                            nmiss = sat(m_miss);
                            resolved = 1'b1;
                        end
                        if (resolved) nph = (m_inj == MAX_INJ) ? 3 : 1;
                    end
                end
                default: if (!enable_i) nph = 0;
            endcase
            if (m_phase != 0) m_lfsr = m_step(m_lfsr);
            if (clear_i) begin
                ninj  = 0;
                ndet  = 0;
                nmiss = 0;
            end
            m_phase = nph;
            m_inj   = ninj;
            m_det   = ndet;
            m_miss  = nmiss;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_inject(input int limit);
        int waited = 0;
        while (inject_o == '0 && waited < limit) begin
            tick(1);
            waited++;
        end
        check("inject_seen_within_bound", |inject_o, 1'b1);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint last_fire;

        rst_i            = 1'b1;
        enable_i         = 1'b0;
        clear_i          = 1'b0;
        mode_i           = 2'd0;
        ch_sel_i         = 1'b1;
        prob_i           = 9'd256;
        pattern_i        = 32'h02A50533;
        addr_lo_i        = 32'h0;
        addr_hi_i        = 32'h100;
        valid_i          = 2'b11;
        addr_i           = {32'h40, 32'h40};
        data_i           = {32'h22222222, 32'h11111111};
        error_detected_i = 1'b0;
        tick(2);
        rst_i  = 1'b0;
        cmp_en = 1'b1;
        tick(1);

        // Reset state.
        check("rst_inj", inj_count_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_inject", inject_o, 0);
        check("rst_passthru", data_o, 64'h22222222_11111111);

        // Always-fire REPLACE on channel 1 in the first armed cycle.
        enable_i = 1'b1;
        tick(1);
        check("A_inject", inject_o, 2'b10);
        check("A_data1", data_o[63:32], 32'h02A50533);
        check("A_data0", data_o[31:0], 32'h11111111);
        tick(1);
        check("A_inj_after", inj_count_o, 1);
        enable_i = 1'b0;
        tick(1);
        check("A_abandon_busy", busy_o, 0);
        check("A_abandon_miss", miss_count_o, 0);
        pulse_clear();
        check("A_cleared", inj_count_o, 0);

        // Clear coinciding with an injection: clear wins.
        enable_i = 1'b1;
        tick(1);
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        check("clr_wins", inj_count_o, 0);
        enable_i = 1'b0;
        tick(1);

        // FLIP with detection 3 cycles after each fire until DONE.
        mode_i    = 2'd1;
        pattern_i = 32'h1;
        enable_i  = 1'b1;
        for (int i = 0; i < MAX_INJ; i++) begin
            wait_inject(50);
            tick(3);
            error_detected_i = 1'b1;
            tick(1);
            error_detected_i = 1'b0;
        end
        tick(1);
        check("B_done", done_o, 1);
        check("B_inj", inj_count_o, 10);
        check("B_det", det_count_o, 10);
        check("B_miss", miss_count_o, 0);
        enable_i = 1'b0;
        tick(1);
        pulse_clear();

        // No detection: each miss resolves DET_TIMEOUT cycles after its fire,
        // so with always-fire the next injection lands DET_TIMEOUT+1 later.
        mode_i    = 2'd3;
        pattern_i = 32'hF0;
        enable_i  = 1'b1;
        last_fire = 0;
        for (int i = 0; i < MAX_INJ; i++) begin
            wait_inject(200);
            if (i > 0) check("C_fire_gap", cyc - last_fire, DET_TIMEOUT + 1);
            last_fire = cyc;
            tick(1);
        end
        tick(DET_TIMEOUT);
        check("C_done", done_o, 1);
        check("C_miss", miss_count_o, 10);
        check("C_det", det_count_o, 0);
        enable_i = 1'b0;
        tick(1);
        pulse_clear();

        // Detection in the timeout cycle counts as detected.
        mode_i   = 2'd2;
        enable_i = 1'b1;
        wait_inject(20);
        tick(DET_TIMEOUT);
        error_detected_i = 1'b1;
        prob_i = 9'd0;
        tick(1);
        error_detected_i = 1'b0;
        check("D_det_wins", det_count_o, 1);
        check("D_no_miss", miss_count_o, 0);
        enable_i = 1'b0;
        tick(1);
        pulse_clear();

        // Address at the exclusive window end, then prob 0, then empty window.
        addr_i   = {32'h100, 32'h100};
        prob_i   = 9'd256;
        enable_i = 1'b1;
        tick(1000);
        check("E_hi_excl", inj_count_o, 0);
        addr_i = {32'h40, 32'h40};
        prob_i = 9'd0;
        tick(1000);
        check("E_prob0", inj_count_o, 0);
        addr_lo_i = 32'h80;
        addr_hi_i = 32'h80;
        prob_i    = 9'd256;
        tick(50);
        check("E_empty_win", inj_count_o, 0);
        enable_i = 1'b0;
        tick(1);
        addr_lo_i = 32'h0;
        addr_hi_i = 32'h100;

        // Enable dropped while waiting, then re-armed.
        enable_i = 1'b1;
        wait_inject(20);
        tick(2);
        enable_i = 1'b0;
        tick(1);
        check("F_idle_busy", busy_o, 0);
        check("F_inj_hold", inj_count_o, 1);
        error_detected_i = 1'b1;
        tick(2);
        error_detected_i = 1'b0;
        check("F_det_ignored", det_count_o, 0);
        enable_i = 1'b1;
        wait_inject(20);
        tick(1);
        check("F_reinject", inj_count_o, 2);

        // Reset while waiting; the LFSR must restart at the seed: low byte
        // 0xE1 misses prob 225, the next value 0xE270 (low 0x70) hits.
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check("G_rst_inj", inj_count_o, 0);
        check("G_rst_busy", busy_o, 0);
        check("G_rst_passthru", data_o, 64'h22222222_11111111);
        prob_i = 9'd225;
        tick(1);
        check("G_first_armed", inject_o, 2'b00);
        tick(1);
        check("G_second_armed", inject_o, 2'b10);

        // Partial probability with periodic detections; model tracks it.
        mode_i = 2'd0;
        prob_i = 9'd100;
        for (int i = 0; i < 300; i++) begin
            error_detected_i = (i % 7 == 3);
            tick(1);
        end
        error_detected_i = 1'b0;
        prob_i = 9'd0;
        tick(1);
        enable_i = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
